// File: rtl/pio_osr.sv
// Output shift register between the TX FIFO and the OUT datapath.
// Serves 1..32-bit shifts with optional autopull, plus blocking and non-blocking PULL.
module pio_osr (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [31:0] fifo_data,
    output logic        fifo_pop,
    input  logic        shift_req,
    input  logic [5:0]  shift_count,
    input  logic        shift_right,
    input  logic        pull_req,
    input  logic        pull_block,
    input  logic [31:0] x_value,
    input  logic        autopull_en,
    input  logic [4:0]  pull_thresh,
    output logic [31:0] out_data,
    output logic        ack,
    output logic        stall,
    output logic [5:0]  osr_count
);
    typedef enum logic [1:0] {IDLE, POP, LOAD} state_t;

    state_t      state, state_nx;
    logic [31:0] osr;
    logic        pull_op, pull_op_nx;
    logic        stall_nx, do_shift, do_xload;
    logic [5:0]  n_eff, thresh, count_sum_sat;
    logic        refill;
    logic [6:0]  count_sum;
    logic [63:0] shr, shl, mask;
    logic [31:0] shift_out, osr_shifted;

    assign n_eff  = (shift_count == 6'd0 || shift_count > 6'd32) ? 6'd32 : shift_count;
    assign thresh = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
    assign refill = autopull_en && (osr_count >= thresh);

    // 64-bit staging keeps a full 32-bit shift well defined and zero-filled.
    assign shr  = {32'b0, osr} >> n_eff;
    assign shl  = {32'b0, osr} << n_eff;
    assign mask = (64'd1 << n_eff) - 64'd1;

    assign shift_out   = shift_right ? (osr & mask[31:0]) : shl[63:32];
    assign osr_shifted = shift_right ? shr[31:0] : shl[31:0];

    assign count_sum     = {1'b0, osr_count} + {1'b0, n_eff};
    assign count_sum_sat = (count_sum > 7'd32) ? 6'd32 : count_sum[5:0];

    always_comb begin
        state_nx   = state;
        pull_op_nx = pull_op;
        stall_nx   = 1'b0;
        do_shift   = 1'b0;
        do_xload   = 1'b0;
        case (state)
            IDLE: begin
                // The ack cycle is the requester's deassert cycle; requests are ignored then.
                if (!ack) begin
                    if (pull_req) begin
                        if (!fifo_empty) begin
                            state_nx   = POP;
                            pull_op_nx = 1'b1;
                        end else if (pull_block) begin
                            stall_nx = 1'b1;
                        end else begin
                            do_xload = 1'b1;
                        end
                    end else if (shift_req) begin
                        if (!refill) begin
                            do_shift = 1'b1;
                        end else if (!fifo_empty) begin
                            state_nx   = POP;
                            pull_op_nx = 1'b0;
                        end else begin
                            stall_nx = 1'b1;
                        end
                    end
                end
            end
            POP:     state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pull_op   <= 1'b0;
            osr       <= 32'd0;
            osr_count <= 6'd32;
            out_data  <= 32'd0;
            ack       <= 1'b0;
            stall     <= 1'b0;
            fifo_pop  <= 1'b0;
        end else begin
            state    <= state_nx;
            pull_op  <= pull_op_nx;
            stall    <= stall_nx;
            fifo_pop <= (state_nx == POP);
            ack      <= 1'b0;
            if (do_shift) begin
                osr       <= osr_shifted;
                out_data  <= shift_out;
                osr_count <= count_sum_sat;
                ack       <= 1'b1;
            end
            if (do_xload) begin
                osr       <= x_value;
                osr_count <= 6'd0;
                ack       <= 1'b1;
            end
            // fifo_data is valid here, one cycle after the edge that sampled fifo_pop.
            if (state == LOAD) begin
                osr       <= fifo_data;
                osr_count <= 6'd0;
                ack       <= pull_op;
            end
        end
    end
endmodule

// File: tb/tb_pio_osr.sv
// Directed bench for pio_osr: a registered-read FIFO model, an arithmetic model of the
// shift register checked on every ack, and literal expectations that pin the model.
module tb_pio_osr;
    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [31:0] fifo_data = 32'd0;
    logic        fifo_pop;
    logic        shift_req, shift_right, pull_req, pull_block, autopull_en;
    logic [5:0]  shift_count;
    logic [31:0] x_value;
    logic [4:0]  pull_thresh;
    logic [31:0] out_data;
    logic        ack, stall;
    logic [5:0]  osr_count;

    int n_cmp = 0;
    int n_err = 0;

    pio_osr dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_pop(fifo_pop), .shift_req(shift_req), .shift_count(shift_count),
        .shift_right(shift_right), .pull_req(pull_req), .pull_block(pull_block),
        .x_value(x_value), .autopull_en(autopull_en), .pull_thresh(pull_thresh),
        .out_data(out_data), .ack(ack), .stall(stall), .osr_count(osr_count)
    );

    always #5 clk = ~clk;

    // 4-deep FIFO with registered read
    logic [31:0] fmem [4];
    int          fcnt = 0, rdp = 0, wrp = 0, pop_cnt = 0;
    logic        push = 1'b0;
    logic [31:0] push_data = 32'd0;

    assign fifo_empty = (fcnt == 0);

    always @(posedge clk) begin
        if (fifo_pop && fcnt > 0) begin
            fifo_data <= fmem[rdp];
            rdp       <= (rdp + 1) % 4;
            pop_cnt   <= pop_cnt + 1;
        end
        if (push) begin
            fmem[wrp] <= push_data;
            wrp       <= (wrp + 1) % 4;
        end
        fcnt <= fcnt + (push ? 1 : 0) - ((fifo_pop && fcnt > 0) ? 1 : 0);
    end

    // model state
    logic [31:0] mosr;
    int          mcount;
    logic [31:0] model_q [$];
    logic [31:0] exp_out;
    logic [5:0]  exp_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // compare process: every ack must carry the modelled result
    always @(negedge clk) begin
        if (!rst && ack) begin
            check("ack_out_data", out_data, exp_out);
            check("ack_osr_count", {26'b0, osr_count}, {26'b0, exp_count});
            check("ack_stall_low", {31'b0, stall}, 32'd0);
        end
        if (fifo_pop)
            check("pop_only_when_nonempty", {31'b0, fcnt > 0}, 32'd1);
    end

    task automatic predict_shift(input int n, input bit right, output int lat);
        int nn, thr;
        longint unsigned p, v;
        thr = (pull_thresh == 5'd0) ? 32 : int'(pull_thresh);
        lat = 1;
        if (autopull_en && mcount >= thr) begin
            mosr   = model_q.pop_front();
            mcount = 0;
            lat    = 4;
        end
        nn = (n == 0 || n > 32) ? 32 : n;
        p  = 64'd1 << nn;
        v  = {32'b0, mosr};
        if (right) begin
            exp_out = 32'(v % p);
            mosr    = 32'(v / p);
        end else begin
            exp_out = 32'(v / (64'd1 << (32 - nn)));
            mosr    = 32'((v * p) % 64'h1_0000_0000);
        end
        mcount    = (mcount + nn > 32) ? 32 : mcount + nn;
        exp_count = 6'(mcount);
    endtask

    task automatic predict_pull(input logic [31:0] xv, output int lat);
        if (model_q.size() > 0) begin
            mosr = model_q.pop_front();
            lat  = 3;
        end else begin
            mosr = xv;
            lat  = 1;
        end
        mcount    = 0;
        exp_count = 6'd0;
    endtask

    task automatic push_word(input logic [31:0] w, input bit to_model);
        push      = 1'b1;
        push_data = w;
        @(posedge clk); #1;
        push = 1'b0;
        if (to_model) model_q.push_back(w);
    endtask

    task automatic run_op(input bit is_pull, input int n, input bit right, input bit blk,
                          input logic [31:0] xv);
        int lat, cyc;
        bit got;
        if (is_pull) predict_pull(xv, lat);
        else         predict_shift(n, right, lat);
        shift_count = 6'(n);
        shift_right = right;
        pull_block  = blk;
        x_value     = xv;
        if (is_pull) pull_req = 1'b1;
        else         shift_req = 1'b1;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (ack) got = 1'b1;
        end
        pull_req  = 1'b0;
        shift_req = 1'b0;
        check(is_pull ? "pull_latency" : "shift_latency", 32'(cyc), 32'(lat));
        @(posedge clk); #1;
    endtask

    initial begin
        int pc, cyc;
        bit got;
        rst = 1'b1;
        shift_req = 1'b0; pull_req = 1'b0; shift_right = 1'b0; pull_block = 1'b0;
        autopull_en = 1'b0; shift_count = 6'd0; x_value = 32'd0; pull_thresh = 5'd0;
        mosr = 32'd0; mcount = 32; exp_out = 32'd0; exp_count = 6'd32;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_osr_count", {26'b0, osr_count}, 32'd32);
        check("rst_out_data", out_data, 32'd0);
        check("rst_ack", {31'b0, ack}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_fifo_pop", {31'b0, fifo_pop}, 32'd0);

        // autopull from an empty register
        autopull_en = 1'b1;
        pull_thresh = 5'd0;
        push_word(32'hDEADBEEF, 1'b1);
        run_op(1'b0, 8, 1'b1, 1'b0, 32'd0);
        check("autopull_out", out_data, 32'h000000EF);
        check("autopull_pops", 32'(pop_cnt), 32'd1);
        run_op(1'b0, 8, 1'b1, 1'b0, 32'd0);
        check("second_out", out_data, 32'h000000BE);
        check("second_count", {26'b0, osr_count}, 32'd16);

        // threshold 16 with osr_count 16 refills
        pull_thresh = 5'd16;
        push_word(32'h0F0F1234, 1'b1);
        run_op(1'b0, 4, 1'b1, 1'b0, 32'd0);
        check("thresh_out", out_data, 32'h00000004);
        check("thresh_count", {26'b0, osr_count}, 32'd4);

        // explicit PULL then left shifts
        autopull_en = 1'b0;
        push_word(32'h12345678, 1'b1);
        run_op(1'b1, 0, 1'b0, 1'b1, 32'd0);
        check("pull_out_unchanged", out_data, 32'h00000004);
        run_op(1'b0, 4, 1'b0, 1'b0, 32'd0);
        check("left4_out", out_data, 32'h00000001);
        run_op(1'b0, 0, 1'b0, 1'b0, 32'd0);
        check("left32_out", out_data, 32'h23456780);
        check("left32_count", {26'b0, osr_count}, 32'd32);
        run_op(1'b0, 8, 1'b1, 1'b0, 32'd0);
        check("empty_shift_out", out_data, 32'd0);

        // non-blocking PULL on empty FIFO
        pc = pop_cnt;
        run_op(1'b1, 0, 1'b0, 1'b0, 32'hA5A5A5A5);
        check("nb_pull_no_pop", 32'(pop_cnt), 32'(pc));
        run_op(1'b0, 40, 1'b1, 1'b0, 32'd0);
        check("shift40_out", out_data, 32'hA5A5A5A5);

        // blocking PULL on empty FIFO
        pc = pop_cnt;
        pull_block = 1'b1;
        pull_req   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("block_stall", {31'b0, stall}, 32'd1);
            check("block_no_pop", {31'b0, fifo_pop}, 32'd0);
        end
        check("block_pop_count", 32'(pop_cnt), 32'(pc));
        mosr = 32'hCAFEF00D; mcount = 0; exp_count = 6'd0;
        push_word(32'hCAFEF00D, 1'b0);
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (ack) got = 1'b1;
        end
        pull_req = 1'b0;
        check("block_latency_after_push", 32'(cyc), 32'd4);
        @(posedge clk); #1;
        run_op(1'b0, 32, 1'b1, 1'b0, 32'd0);
        check("block_loaded", out_data, 32'hCAFEF00D);

        // reset during POP abandons the word in flight
        push_word(32'h55AA55AA, 1'b1);
        pull_block = 1'b1;
        pull_req   = 1'b1;
        @(posedge clk); #1;
        check("pop_seen", {31'b0, fifo_pop}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_count", {26'b0, osr_count}, 32'd32);
        check("mid_rst_out", out_data, 32'd0);
        check("mid_rst_pop", {31'b0, fifo_pop}, 32'd0);
        check("mid_rst_ack", {31'b0, ack}, 32'd0);
        check("mid_rst_stall", {31'b0, stall}, 32'd0);
        pull_req = 1'b0;
        mosr = 32'd0; mcount = 32; exp_out = 32'd0; exp_count = 6'd32;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        autopull_en = 1'b1;
        pull_thresh = 5'd0;
        run_op(1'b0, 8, 1'b1, 1'b0, 32'd0);
        check("post_rst_refill", out_data, 32'h000000AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pio_osr.md
Name: pio_osr

Overview:
- Output shift register stage that sits directly downstream of the 4-deep 32-bit TX FIFO.
- Pops 32-bit words from the FIFO into a shift register.
- Serves shift requests of 1–32 bits to the state machine's OUT datapath, with optional autopull and explicit blocking or non-blocking PULL.
- Handles the FIFO's registered read: read data is valid the cycle after the edge that samples the pop request.

Parameters:
- None. All configuration comes from ports, so the state machine can reconfigure at run time.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- fifo_empty  in  1  TX FIFO empty flag
- fifo_data  in  32  TX FIFO read data; valid the cycle after the edge that sampled fifo_pop=1
- fifo_pop  out  1  registered pop request to the FIFO, one-cycle pulse
- shift_req  in  1  request a shift-out of shift_count bits
- shift_count  in  6  bits per shift, 1..32; values 0 and 33..63 are treated as 32
- shift_right  in  1  1 = shift out the LSBs (osr >> n); 0 = shift out the MSBs (osr << n)
- pull_req  in  1  explicit PULL request
- pull_block  in  1  1 = blocking PULL, 0 = non-blocking
- x_value  in  32  value loaded by a non-blocking PULL when the FIFO is empty
- autopull_en  in  1  enable autopull
- pull_thresh  in  5  autopull threshold; 0 means 32
- out_data  out  32  shifted-out bits, right-aligned, upper bits zero
- ack  out  1  one-cycle pulse: requested operation complete
- stall  out  1  high while a request is waiting on an empty FIFO
- osr_count  out  6  bits consumed since the last load, 0..32

Behaviour:
- Reset is asynchronous, active-high, on rst, and is the only reset. Reset values:
  - osr = 0, osr_count = 32 (register empty)
  - out_data = 0, ack = 0, stall = 0, fifo_pop = 0
  - state = IDLE
- Reset mid-operation abandons the operation immediately; any FIFO word in flight is discarded.
- Request protocol:
  - Requester holds shift_req or pull_req, with all operands stable, until ack.
  - Requester deasserts in the ack cycle; the block ignores requests while ack=1.
  - If both requests are high, pull_req is served and shift_req stays pending.
- States:
  - IDLE — service requests.
  - POP — fifo_pop=1 this cycle.
  - LOAD — capture fifo_data.
- IDLE, shift_req, no refill needed:
  - Refill is needed when autopull_en=1 and osr_count >= thresh (thresh = 32 when pull_thresh = 0).
  - At the edge, with n = effective shift_count:
    - shift_right=1: out_data = osr[n-1:0], osr <= osr >> n.
    - shift_right=0: out_data = osr[31:32-n], osr <= osr << n.
    - Vacated bits are zero-filled.
    - osr_count <= min(osr_count + n, 32).
    - ack = 1 in the next cycle.
  - Latency is 1 cycle.
  - Shifting with autopull off and osr_count = 32 still executes and returns zeros.
- IDLE, shift_req, refill needed:
  - FIFO non-empty: go to POP, stall = 0.
  - FIFO empty: stay in IDLE with stall = 1 until the FIFO becomes non-empty.
  - The refill sequence is POP → LOAD (osr <= fifo_data, osr_count <= 0) → IDLE, after which the shift executes normally.
  - Total latency from request to ack is 4 cycles.
- IDLE, pull_req:
  - FIFO non-empty: POP → LOAD; ack in the cycle after LOAD. Latency is 3 cycles. out_data is unchanged.
  - FIFO empty, pull_block = 1: stall = 1, wait in IDLE.
  - FIFO empty, pull_block = 0: osr <= x_value, osr_count <= 0, ack next cycle.
- stall is registered. It clears in the cycle the FIFO-non-empty condition is acted upon, i.e. when the block enters POP.
- fifo_pop is asserted only in POP, and POP is entered only while fifo_empty = 0. There is never more than one pop outstanding.
- osr_count saturates at 32; no wrap.

Test Plan:
- Reset, then idle: osr_count = 32, out_data = 0, ack = 0, stall = 0, fifo_pop = 0.
- Autopull shift from empty register:
  - Setup: autopull_en = 1, pull_thresh = 0, FIFO holds 0xDEADBEEF; shift_req, shift_count = 8, shift_right = 1.
  - Expect: fifo_pop pulses one cycle, then out_data = 0x000000EF with ack 4 cycles after the request.
  - A following 8-bit shift returns 0xBE with 1-cycle latency; osr_count = 16.
- Left shifts from 0x12345678 (explicit PULL first, autopull off):
  - shift_count = 4, shift_right = 0 → out_data = 0x1, osr = 0x23456780.
  - shift_count = 0 (treated as 32) → out_data = 0x23456780, osr_count = 32.
- Blocking PULL with FIFO empty:
  - stall = 1 for 5 cycles, no fifo_pop.
  - Push 0xCAFEF00D → POP, LOAD, ack; osr = 0xCAFEF00D, osr_count = 0.
- Non-blocking PULL, FIFO empty, x_value = 0xA5A5A5A5 → ack after 1 cycle, osr = 0xA5A5A5A5, no fifo_pop.
- Reset and threshold edge cases:
  - Assert rst during POP → all outputs return to reset values immediately.
  - With pull_thresh = 16 and osr_count = 16, a shift triggers a refill.
